// File: rtl/bus_ctrl.sv
// bus_ctrl: single-master controller for a set of memory-mapped slaves.
// The upper address bits select one of NSLV slaves. An access to a
// disabled slave completes with a bus error, and so does an access whose
// slave does not acknowledge within TIMEOUT wait cycles. Every output is
// driven from a register, so the slave side holds still for the whole
// access and the CPU side sees clean one-cycle ack/err pulses.
module bus_ctrl #(
    parameter int              AW      = 16,
    parameter int              DW      = 16,
    parameter int              NSLV    = 4,
    parameter logic [NSLV-1:0] SLV_EN  = {NSLV{1'b1}},
    parameter int              TIMEOUT = 15
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_req,
    input  logic                          i_rw,
    input  logic [AW-1:0]                 i_addr,
    input  logic [DW-1:0]                 i_dat,
    output logic [DW-1:0]                 o_dat,
    output logic                          o_ack,
    output logic                          o_err,
    output logic                          o_busy,
    output logic [NSLV-1:0]               o_cs,
    output logic                          o_we,
    output logic [AW-$clog2(NSLV)-1:0]    o_saddr,
    output logic [DW-1:0]                 o_sdat,
    input  logic [NSLV*DW-1:0]            i_sdat,
    input  logic [NSLV-1:0]               i_sack
);

    localparam int SW = $clog2(NSLV);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
    localparam logic [DW-1:0]   DAT_ERR  = {DW{1'b1}};
    localparam logic [NSLV-1:0] CS_NONE  = {NSLV{1'b0}};
    localparam logic [NSLV-1:0] CS_ONE   = {{(NSLV-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ERRW   = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;

    // Transfer context captured when a request is accepted
    logic [SW-1:0]    slv_r;
    logic [SW-1:0]    slv_s;
    logic             rw_r;
    logic             rw_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;

    // Next values of the registered outputs
    logic [DW-1:0]    dat_s;
    logic             ack_s;
    logic             err_s;
    logic             busy_s;
    logic [NSLV-1:0]  cs_s;
    logic             we_s;
    logic [AW-SW-1:0] saddr_s;
    logic [DW-1:0]    wdat_s;

    // Decode of the incoming request and of the currently selected slave
    logic [SW-1:0]    req_slv_s;
    logic             req_en_s;
    logic             sel_ack_s;
    logic [DW-1:0]    sel_rdat_s;
    logic [DW-1:0]    rdat_arr_s [NSLV];

    for (genvar g = 0; g < NSLV; g++) begin : g_rdat
        assign rdat_arr_s[g] = i_sdat[g*DW +: DW];
    end

    assign req_slv_s  = i_addr[AW-1 -: SW];
    assign req_en_s   = SLV_EN[req_slv_s];
    // Only the latched slave's ack and data are ever looked at; the others
    // may toggle freely.
    assign sel_ack_s  = i_sack[slv_r];
    assign sel_rdat_s = rdat_arr_s[slv_r];

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output decode; everything holds unless changed
    always_comb begin
        state_s = state_r;
        slv_s   = slv_r;
        rw_s    = rw_r;
        cnt_s   = cnt_r;
        dat_s   = o_dat;
        ack_s   = 1'b0;
        err_s   = 1'b0;
        busy_s  = o_busy;
        cs_s    = o_cs;
        we_s    = o_we;
        saddr_s = o_saddr;
        wdat_s  = o_sdat;

        case (state_r)
            IDLE: begin
                if (i_req) begin
                    if (req_en_s) begin
                        // Capture the whole request so later CPU-side
                        // changes cannot disturb the access.
                        state_s = ACCESS;
                        slv_s   = req_slv_s;
                        rw_s    = i_rw;
                        cnt_s   = CNT_ZERO;
                        saddr_s = i_addr[AW-SW-1:0];
                        wdat_s  = i_dat;
                        cs_s    = CS_ONE << req_slv_s;
                        we_s    = ~i_rw;
                        busy_s  = 1'b1;
                    end else begin
                        // Disabled slave: never select it, report an
                        // error on the next edge.
                        state_s = ERRW;
                        cs_s    = CS_NONE;
                        we_s    = 1'b0;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            ACCESS: begin
                if (sel_ack_s) begin
                    // An ack wins even in the final timeout cycle.
                    state_s = IDLE;
                    ack_s   = 1'b1;
                    err_s   = 1'b0;
                    cs_s    = CS_NONE;
                    we_s    = 1'b0;
                    busy_s  = 1'b0;
                    if (rw_r) begin
                        dat_s = sel_rdat_s;
                    end else begin
                        dat_s = o_dat;
                    end
                end else if (cnt_r == CNT_MAX) begin
                    state_s = IDLE;
                    ack_s   = 1'b1;
                    err_s   = 1'b1;
                    dat_s   = DAT_ERR;
                    cs_s    = CS_NONE;
                    we_s    = 1'b0;
                    busy_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ERRW: begin
                state_s = IDLE;
                ack_s   = 1'b1;
                err_s   = 1'b1;
                dat_s   = DAT_ERR;
                cs_s    = CS_NONE;
                we_s    = 1'b0;
                busy_s  = 1'b0;
            end

            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                cs_s    = CS_NONE;
                we_s    = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Transfer context and wait counter registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            slv_r <= {SW{1'b0}};
            rw_r  <= 1'b0;
            cnt_r <= CNT_ZERO;
        end else begin
            slv_r <= slv_s;
            rw_r  <= rw_s;
            cnt_r <= cnt_s;
        end
    end

    // Registered CPU-side and slave-side outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_dat   <= {DW{1'b0}};
            o_ack   <= 1'b0;
            o_err   <= 1'b0;
            o_busy  <= 1'b0;
            o_cs    <= CS_NONE;
            o_we    <= 1'b0;
            o_saddr <= {(AW-SW){1'b0}};
            o_sdat  <= {DW{1'b0}};
        end else begin
            o_dat   <= dat_s;
            o_ack   <= ack_s;
            o_err   <= err_s;
            o_busy  <= busy_s;
            o_cs    <= cs_s;
            o_we    <= we_s;
            o_saddr <= saddr_s;
            o_sdat  <= wdat_s;
        end
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// Bench for bus_ctrl: directed scenarios plus randomized transfers. The
// stimulus side pushes the expected outcome of each transfer into a queue;
// a monitor on the falling edge checks slave-side outputs while a slave is
// selected and pops/compares an entry on every o_ack.
`timescale 1ns/1ps
module tb_bus_ctrl;

    localparam int              AW      = 16;
    localparam int              DW      = 16;
    localparam int              NSLV    = 4;
    localparam int              TIMEOUT = 15;
    localparam logic [NSLV-1:0] EN      = 4'b1110;

    logic              i_clk   = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_req   = 1'b0;
    logic              i_rw    = 1'b0;
    logic [AW-1:0]     i_addr  = '0;
    logic [DW-1:0]     i_dat   = '0;
    logic [DW-1:0]     o_dat;
    logic              o_ack;
    logic              o_err;
    logic              o_busy;
    logic [NSLV-1:0]   o_cs;
    logic              o_we;
    logic [AW-3:0]     o_saddr;
    logic [DW-1:0]     o_sdat;
    logic [NSLV*DW-1:0] i_sdat;
    logic [NSLV-1:0]   i_sack;

    bus_ctrl #(
        .AW(AW), .DW(DW), .NSLV(NSLV), .SLV_EN(EN), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_rw(i_rw),
        .i_addr(i_addr), .i_dat(i_dat), .o_dat(o_dat), .o_ack(o_ack),
        .o_err(o_err), .o_busy(o_busy), .o_cs(o_cs), .o_we(o_we),
        .o_saddr(o_saddr), .o_sdat(o_sdat), .i_sdat(i_sdat), .i_sack(i_sack)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    // The target slave acks after plan_wait cycles of being selected
    // (negative = never). All other ack lines carry random noise.
    int              tgt       = 0;
    int              plan_wait = -1;
    int              acc_cnt   = 0;
    logic [NSLV-1:0] noise     = '0;
    logic [DW-1:0]   sdat_mem [NSLV];

    initial for (int s = 0; s < NSLV; s++) sdat_mem[s] = '0;

    // Noise and selected-cycle counter for the slave model
    always @(posedge i_clk) begin
        noise <= NSLV'($urandom);
        if (o_cs[tgt]) acc_cnt <= acc_cnt + 1;
        else           acc_cnt <= 0;
    end

    // Slave ack and read-data drivers
    always_comb begin
        i_sack = noise;
        if (o_cs[tgt]) i_sack[tgt] = (plan_wait >= 0) && (acc_cnt == plan_wait);
        i_sdat = '0;
        for (int s = 0; s < NSLV; s++) i_sdat[s*DW +: DW] = sdat_mem[s];
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int              ack_cyc;
        bit              err;
        logic [DW-1:0]   dat;
        logic [NSLV-1:0] cs;
        bit              we;
        logic [AW-3:0]   saddr;
        logic [DW-1:0]   sdat;
        int              cs_cycles;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] model_dat = '0;

    // Issue a request in the drive phase while the controller is idle.
    task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdat,
                         input logic [DW-1:0] rdat, input int wt);
        exp_t e;
        int   k;
        int   wn;
        bit   tmo;
        k = int'(addr[AW-1:AW-2]);
        for (int s = 0; s < NSLV; s++) sdat_mem[s] = DW'($urandom);
        sdat_mem[k] = rdat;
        tgt       = k;
        plan_wait = wt;
        i_req  = 1'b1;
        i_rw   = rw;
        i_addr = addr;
        i_dat  = wdat;
        e.cs = '0; e.we = 1'b0; e.saddr = '0; e.sdat = '0; e.cs_cycles = 0;
        if (!EN[k]) begin
            e.err     = 1'b1;
            e.dat     = '1;
            e.ack_cyc = cyc + 2;
        end else begin
            tmo         = (wt < 0) || (wt > TIMEOUT);
            wn          = tmo ? TIMEOUT : wt;
            e.ack_cyc   = cyc + 2 + wn;
            e.err       = tmo;
            e.dat       = tmo ? '1 : (rw ? rdat : model_dat);
            e.cs        = 4'b0001 << k;
            e.we        = ~rw;
            e.saddr     = addr[AW-3:0];
            e.sdat      = wdat;
            e.cs_cycles = wn + 1;
        end
        model_dat = e.dat;
        expq.push_back(e);
    endtask

    // Wait (bounded) until o_ack is visible; optionally scramble CPU inputs
    // meanwhile, which must not affect the running transfer.
    task automatic wait_ack(input bit scramble);
        int n;
        n = 0;
        @(posedge i_clk); #1;
        while (!o_ack && n < 40) begin
            if (scramble) begin
                i_addr = AW'($urandom);
                i_dat  = DW'($urandom);
                i_rw   = 1'($urandom);
                i_req  = 1'($urandom);
            end
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: no o_ack within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cs"},    o_cs,    '0);
        chk({tag, "_we"},    o_we,    '0);
        chk({tag, "_ack"},   o_ack,   '0);
        chk({tag, "_err"},   o_err,   '0);
        chk({tag, "_busy"},  o_busy,  '0);
        chk({tag, "_dat"},   o_dat,   '0);
        chk({tag, "_saddr"}, o_saddr, '0);
        chk({tag, "_sdat"},  o_sdat,  '0);
    endtask

    // ---------------- monitor ----------------
    int   cs_run = 0;
    exp_t mon_e;

    // Compare DUT outputs against the head of the expectation queue
    always @(negedge i_clk) begin
        if (!i_reset) begin
            cs_run = 0;
        end else begin
            if (o_cs != '0) begin
                cs_run++;
                if (expq.size() == 0) begin
                    chk("cs_without_transfer", o_cs, '0);
                end else begin
                    chk("cs",    o_cs,    expq[0].cs);
                    chk("we",    o_we,    expq[0].we);
                    chk("saddr", o_saddr, expq[0].saddr);
                    chk("sdat",  o_sdat,  expq[0].sdat);
                    chk("busy",  o_busy,  1'b1);
                end
            end
            if (o_err && !o_ack) chk("err_without_ack", o_err, 1'b0);
            if (o_ack) begin
                if (expq.size() == 0) begin
                    chk("unexpected_ack", o_ack, 1'b0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("ack_cycle",   cyc,    mon_e.ack_cyc);
                    chk("err",         o_err,  mon_e.err);
                    chk("rdata",       o_dat,  mon_e.dat);
                    chk("cs_cycles",   cs_run, mon_e.cs_cycles);
                    chk("cs_at_ack",   o_cs,   '0);
                    chk("we_at_ack",   o_we,   1'b0);
                    chk("busy_at_ack", o_busy, 1'b0);
                end
                cs_run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wt;
        int sel;
        int gap;

        // Reset state
        #1 i_reset = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge i_clk);
        #3 i_reset = 1'b1;
        @(posedge i_clk); #1;

        // Read 0x4010, slave 1 zero-wait with 0xBEEF
        issue(1'b1, 16'h4010, 16'h0000, 16'hBEEF, 0);
        wait_ack(1'b0);
        i_req = 1'b0;
        @(posedge i_clk); #1;

        // Write 0x1234 to 0xC005, slave 3 acks after 3 waits
        issue(1'b0, 16'hC005, 16'h1234, 16'h0000, 3);
        wait_ack(1'b1);
        i_req = 1'b0;
        @(posedge i_clk); #1;

        // Read 0x8000, slave 2 never acks: timeout
        issue(1'b1, 16'h8000, 16'h0000, 16'h0000, -1);
        wait_ack(1'b1);
        i_req = 1'b0;
        @(posedge i_clk); #1;

        // Disabled slave 0
        issue(1'b1, 16'h0001, 16'h0000, 16'h7777, 0);
        wait_ack(1'b0);
        i_req = 1'b0;
        @(posedge i_clk); #1;

        // Ack in the last allowed cycle wins; one before that too
        issue(1'b1, 16'h4123, 16'h0000, 16'hA5A5, TIMEOUT);
        wait_ack(1'b1);
        i_req = 1'b0;
        issue(1'b1, 16'h8456, 16'h0000, 16'h3C3C, TIMEOUT - 1);
        wait_ack(1'b0);
        i_req = 1'b0;
        @(posedge i_clk); #1;

        // Back-to-back: request held across o_ack with a new address
        issue(1'b1, 16'h4010, 16'h0000, 16'hBEEF, 0);
        wait_ack(1'b0);
        issue(1'b1, 16'h4002, 16'h0000, 16'h5A5A, 1);
        wait_ack(1'b0);
        i_req = 1'b0;
        @(posedge i_clk); #1;

        // Reset in the middle of an access
        issue(1'b1, 16'h8000, 16'h0000, 16'h0000, -1);
        repeat (4) begin @(posedge i_clk); #1; end
        chk("busy_before_reset", o_busy, 1'b1);
        #2 i_reset = 1'b0;
        #1 check_all_zero("async_reset");
        i_req = 1'b0;
        expq.delete();
        model_dat = '0;
        plan_wait = -1;
        repeat (3) begin
            @(posedge i_clk); #1;
            chk("ack_in_reset", o_ack, 1'b0);
        end
        #2 i_reset = 1'b1;
        @(posedge i_clk); #1;
        issue(1'b1, 16'h4010, 16'h0000, 16'hBEEF, 0);
        wait_ack(1'b0);
        i_req = 1'b0;
        @(posedge i_clk); #1;

        // Randomized transfers
        for (int t = 0; t < 60; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      wt = int'($urandom_range(0, 4));
            else if (sel < 8) wt = int'($urandom_range(TIMEOUT - 1, TIMEOUT + 1));
            else              wt = -1;
            issue(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), wt);
            wait_ack(1'($urandom));
            i_req = 1'b0;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge i_clk); #1; end
        end

        repeat (3) begin @(posedge i_clk); #1; end
        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
